// File: rtl/cfi_shadow_stack_checker.sv
// Commit-stage CFI log consumer: buffers per-port logs in an in-order FIFO and replays them
// against a hardware shadow stack. Optional perf counters under `CFI_SS_PERF_CNT_EN.
package cfi_ss_pkg;
    localparam int unsigned VLEN = 64;

    // A log with neither flag set is a branch or plain jump: consumed without stack effect.
    typedef struct packed {
        logic [VLEN-1:0] addr_pc;
        logic [VLEN-1:0] addr_npc;
        logic [VLEN-1:0] addr_target;
        logic            is_call;
        logic            is_return;
    } cfi_log_t;
endpackage

module cfi_shadow_stack_checker
    import cfi_ss_pkg::*;
#(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned SS_DEPTH        = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 enable_i,
    input  cfi_log_t [NR_COMMIT_PORTS-1:0]       log_i,
    input  logic [NR_COMMIT_PORTS-1:0]           cfi_i,
    input  logic                                 err_clear_i,
    output logic                                 stall_o,
    output logic                                 irq_o,
    output logic [1:0]                           err_cause_o,
    output logic [VLEN-1:0]                      err_pc_o,
    output logic                                 fifo_ovf_o
`ifdef CFI_SS_PERF_CNT_EN
    ,
    output logic [31:0]                          calls_o,
    output logic [31:0]                          rets_o
`endif
);
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned EW  = CW + 1;
    localparam int unsigned SW  = $clog2(SS_DEPTH);
    localparam int unsigned SPW = SW + 1;

    typedef enum logic {ST_RUN, ST_ERROR} state_e;

    cfi_log_t        fifo_q [FIFO_DEPTH];
    logic [VLEN-1:0] ss_q   [SS_DEPTH];

    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [SPW-1:0]  sp_q, sp_d;
    state_e          state_q, state_d;
    logic            irq_q, ovf_q;
    logic [1:0]      cause_q;
    logic [VLEN-1:0] pc_q;

    logic [NR_COMMIT_PORTS-1:0] wr_en;
    logic [PW-1:0]              wr_idx [NR_COMMIT_PORTS];
    logic [CW-1:0]              n_enq;
    logic                       drop;

    cfi_log_t        head;
    logic [VLEN-1:0] tos;
    logic            do_check, viol, do_pop, do_push;
    logic [1:0]      viol_cause;
    logic [SPW-1:0]  sp_after_pop;

    // Fit is judged against the registered count only; a same-cycle drain does not free a slot.
    always_comb begin
        wr_en = '0;
        drop  = 1'b0;
        n_enq = '0;
        for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
            wr_idx[p] = wr_ptr_q + PW'(n_enq);
            if (enable_i && cfi_i[p] && !err_clear_i) begin
                if ((EW'(count_q) + EW'(n_enq)) < EW'(FIFO_DEPTH)) begin
                    wr_en[p] = 1'b1;
                    n_enq    = n_enq + CW'(1);
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
            if (wr_en[p]) fifo_q[wr_idx[p]] <= log_i[p];
        end
    end

    assign head     = fifo_q[rd_ptr_q];
    assign tos      = ss_q[SW'(sp_q - SPW'(1))];
    assign do_check = (state_q == ST_RUN) && (count_q != '0) && !err_clear_i;

    // A combined call+return entry pops/compares first, then pushes the new link.
    always_comb begin
        viol       = 1'b0;
        viol_cause = 2'd0;
        do_pop     = 1'b0;
        do_push    = 1'b0;
        if (do_check) begin
            if (head.is_return) begin
                if (sp_q == '0) begin
                    viol       = 1'b1;
                    viol_cause = 2'd2;
                end else if (head.addr_target != tos) begin
                    viol       = 1'b1;
                    viol_cause = 2'd1;
                end else begin
                    do_pop = 1'b1;
                end
            end
            if (head.is_call && !viol) begin
                if ((sp_q - SPW'(do_pop)) == SPW'(SS_DEPTH)) begin
                    viol       = 1'b1;
                    viol_cause = 2'd3;
                end else begin
                    do_push = 1'b1;
                end
            end
        end
    end

    assign sp_after_pop = sp_q - SPW'(do_pop);
    assign sp_d         = viol ? sp_q : (sp_after_pop + SPW'(do_push));

    always_ff @(posedge clk_i) begin
        if (do_push && !viol) ss_q[SW'(sp_after_pop)] <= head.addr_npc;
    end

    always_comb begin
        state_d = state_q;
        if (err_clear_i)  state_d = ST_RUN;
        else if (viol)    state_d = ST_ERROR;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sp_q     <= '0;
            irq_q    <= 1'b0;
            cause_q  <= 2'd0;
            pc_q     <= '0;
            ovf_q    <= 1'b0;
        end else if (err_clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sp_q     <= '0;
            irq_q    <= 1'b0;
            cause_q  <= 2'd0;
            pc_q     <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(n_enq);
            rd_ptr_q <= rd_ptr_q + PW'(do_check);
            count_q  <= count_q + n_enq - CW'(do_check);
            sp_q     <= sp_d;
            if (viol) begin
                irq_q   <= 1'b1;
                cause_q <= viol_cause;
                pc_q    <= head.addr_pc;
            end
            if (drop) ovf_q <= 1'b1;
        end
    end

`ifdef CFI_SS_PERF_CNT_EN
    logic [31:0] calls_q, rets_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            calls_q <= '0;
            rets_q  <= '0;
        end else if (err_clear_i) begin
            calls_q <= '0;
            rets_q  <= '0;
        end else begin
            if (do_check && head.is_call && (calls_q != '1)) calls_q <= calls_q + 32'd1;
            if (do_pop && !viol && (rets_q != '1))           rets_q  <= rets_q + 32'd1;
        end
    end

    assign calls_o = calls_q;
    assign rets_o  = rets_q;
`endif

    assign stall_o     = (CW'(FIFO_DEPTH) - count_q) < CW'(NR_COMMIT_PORTS);
    assign irq_o       = irq_q;
    assign err_cause_o = cause_q;
    assign err_pc_o    = pc_q;
    assign fifo_ovf_o  = ovf_q;

endmodule

// File: tb/tb_cfi_shadow_stack_checker.sv
// Scoreboard bench for cfi_shadow_stack_checker: a queue-based reference model produces the
// expected post-edge outputs for each driven cycle; they are popped and compared after the edge.
module tb_cfi_shadow_stack_checker;
    import cfi_ss_pkg::*;

    localparam int NR = 2;
    localparam int FD = 8;
    localparam int SD = 16;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               enable_i;
    cfi_log_t [NR-1:0]  log_i;
    logic [NR-1:0]      cfi_i;
    logic               err_clear_i;
    logic               stall_o;
    logic               irq_o;
    logic [1:0]         err_cause_o;
    logic [VLEN-1:0]    err_pc_o;
    logic               fifo_ovf_o;
`ifdef CFI_SS_PERF_CNT_EN
    logic [31:0]        calls_o;
    logic [31:0]        rets_o;
`endif

    always #5 clk_i = ~clk_i;

    cfi_shadow_stack_checker #(
        .NR_COMMIT_PORTS(NR),
        .FIFO_DEPTH     (FD),
        .SS_DEPTH       (SD)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .enable_i   (enable_i),
        .log_i      (log_i),
        .cfi_i      (cfi_i),
        .err_clear_i(err_clear_i),
        .stall_o    (stall_o),
        .irq_o      (irq_o),
        .err_cause_o(err_cause_o),
        .err_pc_o   (err_pc_o),
        .fifo_ovf_o (fifo_ovf_o)
`ifdef CFI_SS_PERF_CNT_EN
        ,
        .calls_o    (calls_o),
        .rets_o     (rets_o)
`endif
    );

    typedef struct {
        string       tag;
        logic        irq;
        logic [1:0]  cause;
        logic [63:0] pc;
        logic        ovf;
        logic        stall;
    } exp_t;

    exp_t        sb_q[$];
    cfi_log_t    m_fifo[$];
    logic [63:0] m_ss[$];
    logic        m_irq;
    logic [1:0]  m_cause;
    logic [63:0] m_pc;
    logic        m_ovf;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    function automatic cfi_log_t mk(logic [63:0] pc, logic [63:0] npc, logic [63:0] tgt,
                                    logic call, logic ret);
        cfi_log_t e;
        e.addr_pc     = pc;
        e.addr_npc    = npc;
        e.addr_target = tgt;
        e.is_call     = call;
        e.is_return   = ret;
        return e;
    endfunction

    function automatic void model_clear();
        m_fifo.delete();
        m_ss.delete();
        m_irq   = 1'b0;
        m_cause = 2'd0;
        m_pc    = '0;
        m_ovf   = 1'b0;
    endfunction

    function automatic void model_check(cfi_log_t e);
        logic [63:0] s[$];
        logic [1:0]  c;
        s = m_ss;
        c = 2'd0;
        if (e.is_return) begin
            if (s.size() == 0)                c = 2'd2;
            else if (s[$] != e.addr_target)   c = 2'd1;
            else                              void'(s.pop_back());
        end
        if (e.is_call && c == 2'd0) begin
            if (s.size() == SD) c = 2'd3;
            else                s.push_back(e.addr_npc);
        end
        if (c != 2'd0) begin
            m_irq   = 1'b1;
            m_cause = c;
            m_pc    = e.addr_pc;
        end else begin
            m_ss = s;
        end
    endfunction

    function automatic void model_step(logic en, logic [1:0] v, cfi_log_t l0, cfi_log_t l1,
                                       logic clr);
        int       cnt0;
        int       n;
        cfi_log_t ls[2];
        cfi_log_t e;
        if (clr) begin
            model_clear();
            return;
        end
        ls[0] = l0;
        ls[1] = l1;
        cnt0  = m_fifo.size();
        n     = 0;
        if (!m_irq && cnt0 > 0) begin
            e = m_fifo.pop_front();
            model_check(e);
        end
        for (int p = 0; p < NR; p++) begin
            if (en && v[p]) begin
                if (cnt0 + n < FD) begin
                    m_fifo.push_back(ls[p]);
                    n++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endfunction

    function automatic exp_t model_expect(string tag);
        exp_t x;
        x.tag   = tag;
        x.irq   = m_irq;
        x.cause = m_cause;
        x.pc    = m_pc;
        x.ovf   = m_ovf;
        x.stall = (FD - m_fifo.size()) < NR;
        return x;
    endfunction

    task automatic compare_next();
        exp_t x;
        if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 64'(sb_q.size()), 64'd1);
            return;
        end
        x = sb_q.pop_front();
        $display("[%0t] %s irq=%0b cause=%0d pc=%h ovf=%0b stall=%0b", $time, x.tag,
                 irq_o, err_cause_o, err_pc_o, fifo_ovf_o, stall_o);
        check_eq({x.tag, ".irq"},   64'(irq_o),       64'(x.irq));
        check_eq({x.tag, ".cause"}, 64'(err_cause_o), 64'(x.cause));
        check_eq({x.tag, ".pc"},    64'(err_pc_o),    x.pc);
        check_eq({x.tag, ".ovf"},   64'(fifo_ovf_o),  64'(x.ovf));
        check_eq({x.tag, ".stall"}, 64'(stall_o),     64'(x.stall));
    endtask

    task automatic cyc(string tag, logic en, logic [1:0] v, cfi_log_t l0, cfi_log_t l1,
                       logic clr);
        enable_i    = en;
        cfi_i       = v;
        log_i[0]    = l0;
        log_i[1]    = l1;
        err_clear_i = clr;
        model_step(en, v, l0, l1, clr);
        sb_q.push_back(model_expect(tag));
        @(posedge clk_i);
        #1;
        compare_next();
    endtask

    cfi_log_t z;

    initial begin
        z           = mk('0, '0, '0, 1'b0, 1'b0);
        rst_i       = 1'b1;
        enable_i    = 1'b0;
        cfi_i       = '0;
        log_i[0]    = z;
        log_i[1]    = z;
        err_clear_i = 1'b0;
        model_clear();
        #1;
        sb_q.push_back(model_expect("reset"));
        compare_next();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Matched call/return pair.
        cyc("call_ok", 1, 2'b01, mk(64'h8000_0000, 64'h8000_0004, 0, 1, 0), z, 0);
        cyc("ret_ok",  1, 2'b01, mk(64'h8000_0010, 0, 64'h8000_0004, 0, 1), z, 0);
        cyc("idle",    1, 2'b00, z, z, 0);
        cyc("idle",    1, 2'b00, z, z, 0);

        // Return target mismatch, then clear.
        cyc("call_m",  1, 2'b01, mk(64'h8000_0020, 64'h8000_0004, 0, 1, 0), z, 0);
        cyc("ret_bad", 1, 2'b01, mk(64'h8000_0100, 0, 64'h8000_0008, 0, 1), z, 0);
        cyc("idle",    1, 2'b00, z, z, 0);
        cyc("idle",    1, 2'b00, z, z, 0);
        cyc("clear",   1, 2'b00, z, z, 1);
        cyc("idle",    1, 2'b00, z, z, 0);

        // Underflow on empty stack.
        cyc("ret_uf",  1, 2'b01, mk(64'h8000_0200, 0, 64'h1234, 0, 1), z, 0);
        cyc("idle",    1, 2'b00, z, z, 0);
        cyc("clear",   1, 2'b00, z, z, 1);

        // SS_DEPTH+1 nested calls overflow on the last.
        for (int i = 0; i < SD + 1; i++) begin
            cyc($sformatf("call%0d", i), 1, 2'b01,
                mk(64'h9000_0000 + 64'(i * 4), 64'h9000_0004 + 64'(i * 4), 0, 1, 0), z, 0);
        end
        cyc("idle",    1, 2'b00, z, z, 0);
        cyc("idle",    1, 2'b00, z, z, 0);
        cyc("clear",   1, 2'b00, z, z, 1);

        // Fill the FIFO while an error holds the drain off.
        cyc("ret_uf2", 1, 2'b01, mk(64'h8000_0300, 0, 64'h4, 0, 1), z, 0);
        cyc("idle",    1, 2'b00, z, z, 0);
        for (int i = 0; i < 3; i++) begin
            cyc($sformatf("fill%0d", i), 1, 2'b11, mk(64'hA000 + 64'(i), 0, 0, 0, 0),
                mk(64'hB000 + 64'(i), 0, 0, 0, 0), 0);
        end
        cyc("fill_p0", 1, 2'b01, mk(64'hC000, 0, 0, 0, 0), z, 0);
        cyc("fill_ov", 1, 2'b11, mk(64'hC001, 0, 0, 0, 0), mk(64'hC002, 0, 0, 0, 0), 0);
        cyc("full_ov", 1, 2'b11, mk(64'hC003, 0, 0, 0, 0), mk(64'hC004, 0, 0, 0, 0), 0);
        cyc("clear",   1, 2'b00, z, z, 1);

        // Same-cycle call on port 0 and matching return on port 1.
        cyc("pair",    1, 2'b11, mk(64'h8000_0400, 64'h8000_0404, 0, 1, 0),
            mk(64'h8000_0500, 0, 64'h8000_0404, 0, 1), 0);
        cyc("idle",    1, 2'b00, z, z, 0);
        cyc("idle",    1, 2'b00, z, z, 0);

        // Coroutine entry: pop-compare then push.
        cyc("co_call", 1, 2'b01, mk(64'h8000_0600, 64'hAAA0, 0, 1, 0), z, 0);
        cyc("co_swap", 1, 2'b01, mk(64'h8000_0610, 64'hBBB0, 64'hAAA0, 1, 1), z, 0);
        cyc("co_ret",  1, 2'b01, mk(64'h8000_0620, 0, 64'hBBB0, 0, 1), z, 0);
        cyc("co_uf",   1, 2'b01, mk(64'h8000_0630, 0, 64'hBBB0, 0, 1), z, 0);
        cyc("idle",    1, 2'b00, z, z, 0);
        cyc("clear",   1, 2'b00, z, z, 1);

        // enable_i low: input ignored, buffered entries still checked.
        cyc("en_calls", 1, 2'b11, mk(64'h8000_0700, 64'h7000, 0, 1, 0),
            mk(64'h8000_0704, 64'h7004, 0, 1, 0), 0);
        cyc("en_off",   0, 2'b11, mk(64'h8000_0710, 0, 64'hDEAD, 0, 1),
            mk(64'h8000_0714, 0, 64'hDEAD, 0, 1), 0);
        cyc("idle",     1, 2'b00, z, z, 0);
        cyc("en_bad",   1, 2'b01, mk(64'h8000_0720, 0, 64'h7000, 0, 1), z, 0);
        cyc("idle",     1, 2'b00, z, z, 0);

        // Clear discards same-cycle enqueues.
        cyc("clr_enq",  1, 2'b11, mk(64'h8000_0800, 0, 64'h1, 0, 1),
            mk(64'h8000_0804, 0, 64'h1, 0, 1), 1);
        cyc("idle",     1, 2'b00, z, z, 0);
        cyc("idle",     1, 2'b00, z, z, 0);

        // Async reset with 5 entries buffered and sp=3.
        for (int i = 0; i < 3; i++) begin
            cyc($sformatf("rs_call%0d", i), 1, 2'b01,
                mk(64'h8000_0900 + 64'(i * 4), 64'h5000 + 64'(i * 4), 0, 1, 0), z, 0);
        end
        cyc("rs_bad",  1, 2'b01, mk(64'h8000_0910, 0, 64'hFFFF, 0, 1), z, 0);
        cyc("idle",    1, 2'b00, z, z, 0);
        cyc("rs_buf0", 1, 2'b11, z, z, 0);
        cyc("rs_buf1", 1, 2'b11, z, z, 0);
        cyc("rs_buf2", 1, 2'b01, z, z, 0);
        enable_i = 1'b0;
        cfi_i    = '0;
        #2;
        rst_i = 1'b1;
        #1;
        model_clear();
        sb_q.push_back(model_expect("async_rst"));
        compare_next();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        cyc("post_rst_ret", 1, 2'b01, mk(64'h8000_0A00, 0, 64'h5008, 0, 1), z, 0);
        cyc("idle",         1, 2'b00, z, z, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
